// File: rtl/stage_2_cordic_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : stage_2_cordic_sequencer_if
// Description : Start/done handshake between the stage-2 sequencer and the
//               shared CORDIC core.
//   cordic_start  - one-cycle request, sequencer -> core
//   cordic_angle  - signed Q2.20 angle, sequencer -> core
//   cordic_done   - result-valid pulse, core -> sequencer
//   cordic_result - signed core result, core -> sequencer
// Revision    : 1.0 - initial release
// ============================================================================
interface stage_2_cordic_sequencer_if #(
  parameter int CORDIC_DATA_WIDTH = 22
) ();
  logic                         cordic_start;
  logic [CORDIC_DATA_WIDTH-1:0] cordic_angle;
  logic                         cordic_done;
  logic [CORDIC_DATA_WIDTH-1:0] cordic_result;

  modport master (
    output cordic_start,
    output cordic_angle,
    input  cordic_done,
    input  cordic_result
  );

  modport slave (
    input  cordic_start,
    input  cordic_angle,
    output cordic_done,
    output cordic_result
  );
endinterface
`default_nettype wire

// File: rtl/stage_2_cordic_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : stage_2_cordic_sequencer
// Description : Converts three float angles to signed Q2.20, runs them one at
//               a time through a shared CORDIC core and presents the three
//               results with the registered half/square values.
//   clk, rst          - clock, synchronous active-high reset
//   clk_en            - global enable; low holds every register
//   start             - run request, accepted only in IDLE
//   x_*               - float angles per lane
//   half_in_*/square_in_*   - upstream values, registered on start
//   cordic            - master side of the CORDIC start/done handshake
//   cordic_out_*      - per-lane CORDIC results
//   half_out_*/square_out_* - registered upstream values
//   overflow          - per-lane saturation flags (bit0 = lane one)
//   busy, done        - not-IDLE flag, one-cycle results-valid flag
// Revision    : 1.0 - initial release
// ============================================================================
module stage_2_cordic_sequencer #(
  parameter int FLT_DATA_WIDTH    = 32,
  parameter int CORDIC_DATA_WIDTH = 22,
  parameter int FRAC_BITS         = 20
) (
  input  wire logic                         clk,
  input  wire logic                         rst,
  input  wire logic                         clk_en,
  input  wire logic                         start,
  input  wire logic [FLT_DATA_WIDTH-1:0]    x_one,
  input  wire logic [FLT_DATA_WIDTH-1:0]    x_two,
  input  wire logic [FLT_DATA_WIDTH-1:0]    x_three,
  input  wire logic [FLT_DATA_WIDTH-1:0]    half_in_one,
  input  wire logic [FLT_DATA_WIDTH-1:0]    half_in_two,
  input  wire logic [FLT_DATA_WIDTH-1:0]    half_in_three,
  input  wire logic [FLT_DATA_WIDTH-1:0]    square_in_one,
  input  wire logic [FLT_DATA_WIDTH-1:0]    square_in_two,
  input  wire logic [FLT_DATA_WIDTH-1:0]    square_in_three,
  stage_2_cordic_sequencer_if.master        cordic,
  output logic      [CORDIC_DATA_WIDTH-1:0] cordic_out_one,
  output logic      [CORDIC_DATA_WIDTH-1:0] cordic_out_two,
  output logic      [CORDIC_DATA_WIDTH-1:0] cordic_out_three,
  output logic      [FLT_DATA_WIDTH-1:0]    half_out_one,
  output logic      [FLT_DATA_WIDTH-1:0]    half_out_two,
  output logic      [FLT_DATA_WIDTH-1:0]    half_out_three,
  output logic      [FLT_DATA_WIDTH-1:0]    square_out_one,
  output logic      [FLT_DATA_WIDTH-1:0]    square_out_two,
  output logic      [FLT_DATA_WIDTH-1:0]    square_out_three,
  output logic      [2:0]                   overflow,
  output logic                              busy,
  output logic                              done
);

  localparam int W          = CORDIC_DATA_WIDTH;
  localparam int MANT_W     = 24;
  // Unbiased exponents at or above this many integer bits do not fit.
  localparam int INT_BITS   = W - 1 - FRAC_BITS;
  localparam int SAT_EXP    = 127 + INT_BITS;
  // Right shift applied to the 24-bit mantissa for biased exponent 0.
  localparam int SHIFT_BASE = 127 + (MANT_W - 1) - FRAC_BITS;
  localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NEG_MAX = {1'b1, {(W-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [1:0]                lane;
  logic [W-1:0]              angle_q  [3];
  logic [W-1:0]              out_q    [3];
  logic [FLT_DATA_WIDTH-1:0] half_q   [3];
  logic [FLT_DATA_WIDTH-1:0] square_q [3];
  logic [2:0]                overflow_q;

  logic [FLT_DATA_WIDTH-1:0] x_in      [3];
  logic [FLT_DATA_WIDTH-1:0] half_in   [3];
  logic [FLT_DATA_WIDTH-1:0] square_in [3];
  logic [W:0]                conv      [3];  // {overflow, Q2.20 angle}

  assign x_in[0]      = x_one;
  assign x_in[1]      = x_two;
  assign x_in[2]      = x_three;
  assign half_in[0]   = half_in_one;
  assign half_in[1]   = half_in_two;
  assign half_in[2]   = half_in_three;
  assign square_in[0] = square_in_one;
  assign square_in[1] = square_in_two;
  assign square_in[2] = square_in_three;

  // Float -> signed fixed point. Truncates toward zero in magnitude; the
  // sign is applied afterwards, so negative values truncate toward zero too.
  function automatic logic [W:0] to_fixed(input logic [FLT_DATA_WIDTH-1:0] f);
    logic [7:0]        ex;
    logic [MANT_W-1:0] mant;
    logic [MANT_W-1:0] shifted;
    logic [W-1:0]      mag;
    int                sh;
    ex      = f[30:23];
    mant    = {1'b1, f[22:0]};
    sh      = SHIFT_BASE - int'(ex);
    shifted = '0;
    if (ex == 8'd0) return '0;
    if (int'(ex) >= SAT_EXP) return {1'b1, (f[31] ? NEG_MAX : POS_MAX)};
    if (sh < MANT_W) shifted = mant >> sh;
    mag = W'(shifted);
    return {1'b0, (f[31] ? (~mag + W'(1)) : mag)};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_conv
    assign conv[g] = to_fixed(x_in[g]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (clk_en) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (cordic.cordic_done) state_next = (lane == 2'd2) ? ST_DONE : ST_ISSUE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane       <= '0;
      overflow_q <= '0;
      for (int i = 0; i < 3; i++) begin
        angle_q[i]  <= '0;
        out_q[i]    <= '0;
        half_q[i]   <= '0;
        square_q[i] <= '0;
      end
    end else if (clk_en) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            lane <= '0;
            for (int i = 0; i < 3; i++) begin
              angle_q[i]    <= conv[i][W-1:0];
              overflow_q[i] <= conv[i][W];
              half_q[i]     <= half_in[i];
              square_q[i]   <= square_in[i];
            end
          end
        end
        ST_WAIT: begin
          if (cordic.cordic_done) begin
            out_q[lane] <= cordic.cordic_result;
            if (lane != 2'd2) lane <= lane + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Gating with clk_en keeps a stalled ISSUE cycle from issuing twice.
  assign cordic.cordic_start = (state == ST_ISSUE) && clk_en;
  // lane only changes on leaving WAIT, so the angle is stable while the
  // core works on it.
  assign cordic.cordic_angle = angle_q[lane];

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  assign cordic_out_one   = out_q[0];
  assign cordic_out_two   = out_q[1];
  assign cordic_out_three = out_q[2];
  assign half_out_one     = half_q[0];
  assign half_out_two     = half_q[1];
  assign half_out_three   = half_q[2];
  assign square_out_one   = square_q[0];
  assign square_out_two   = square_q[1];
  assign square_out_three = square_q[2];
  assign overflow         = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_stage_2_cordic_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_2_cordic_sequencer
// Description : Self-checking bench for stage_2_cordic_sequencer with a
//               behavioural CORDIC core (result = angle + 1, latency L).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_2_cordic_sequencer;
  localparam int FW = 32;
  localparam int CW = 22;
  localparam int FB = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b1;
  logic start = 1'b0;
  logic [FW-1:0] x_in [3];
  logic [FW-1:0] half_in [3];
  logic [FW-1:0] square_in [3];
  logic [CW-1:0] cordic_out [3];
  logic [FW-1:0] half_out [3];
  logic [FW-1:0] square_out [3];
  logic [2:0] overflow;
  logic busy, done;

  logic          model_done = 1'b0;
  logic          stray_done = 1'b0;
  logic [CW-1:0] model_result = '0;

  stage_2_cordic_sequencer_if #(.CORDIC_DATA_WIDTH(CW)) cordic_bus ();
  assign cordic_bus.cordic_done   = model_done | stray_done;
  assign cordic_bus.cordic_result = model_result;

  stage_2_cordic_sequencer #(
    .FLT_DATA_WIDTH(FW), .CORDIC_DATA_WIDTH(CW), .FRAC_BITS(FB)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start),
    .x_one(x_in[0]), .x_two(x_in[1]), .x_three(x_in[2]),
    .half_in_one(half_in[0]), .half_in_two(half_in[1]), .half_in_three(half_in[2]),
    .square_in_one(square_in[0]), .square_in_two(square_in[1]), .square_in_three(square_in[2]),
    .cordic(cordic_bus),
    .cordic_out_one(cordic_out[0]), .cordic_out_two(cordic_out[1]), .cordic_out_three(cordic_out[2]),
    .half_out_one(half_out[0]), .half_out_two(half_out[1]), .half_out_three(half_out[2]),
    .square_out_one(square_out[0]), .square_out_two(square_out[1]), .square_out_three(square_out[2]),
    .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural core: a request seen at a clock edge yields done L cycles
  // after the request cycle. It ignores the DUT reset on purpose.
  int            core_lat = 1;
  int            core_ctr = 0;
  logic [CW-1:0] core_val = '0;
  always @(posedge clk) begin
    logic d;
    d = 1'b0;
    if (core_ctr > 0) begin
      core_ctr = core_ctr - 1;
      if (core_ctr == 0) d = 1'b1;
    end
    if (cordic_bus.cordic_start) begin
      core_val = cordic_bus.cordic_angle + CW'(1);
      core_ctr = core_lat - 1;
      if (core_ctr == 0) d = 1'b1;
    end
    model_done   <= d;
    model_result <= core_val;
  end

  // Observers sampled mid-cycle.
  logic [CW-1:0] issued_q [$];
  int            done_hits = 0;
  int            done_cyc = -1;
  int            unstable = 0;
  logic          issued = 1'b0;
  logic [CW-1:0] last_angle = '0;
  always @(negedge clk) begin
    if (cordic_bus.cordic_start) begin
      issued_q.push_back(cordic_bus.cordic_angle);
      last_angle = cordic_bus.cordic_angle;
      issued = 1'b1;
    end else if (busy && issued && cordic_bus.cordic_angle !== last_angle) begin
      unstable++;
    end
    if (!busy) issued = 1'b0;
    if (done) begin
      done_hits++;
      done_cyc = cyc;
    end
  end

  int total = 0;
  int bad = 0;
  int base_cyc = 0;
  logic [CW-1:0] exp_angle [3];
  logic [2:0]    exp_ovf;

  // Reference conversion from the real value of the float.
  function automatic void ref_conv(input logic [31:0] f, output logic [CW-1:0] v, output logic ovf);
    int     e;
    real    mag;
    longint imag;
    e   = int'(f[30:23]);
    ovf = 1'b0;
    v   = '0;
    if (e == 0) return;
    mag = (1.0 + real'(f[22:0]) / 8388608.0) * 1048576.0;
    for (int i = 127; i < e; i++) mag = mag * 2.0;
    for (int i = e; i < 127; i++) mag = mag / 2.0;
    if (e == 255 || mag >= 2097152.0) begin
      ovf = 1'b1;
      mag = 2097151.0;
    end
    imag = $rtoi(mag);
    v = f[31] ? CW'(-imag) : CW'(imag);
  endfunction

  task automatic set_inputs(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    logic [CW-1:0] v;
    logic          o;
    x_in[0] = a; x_in[1] = b; x_in[2] = c;
    for (int i = 0; i < 3; i++) begin
      half_in[i]   = $urandom;
      square_in[i] = $urandom;
      ref_conv(x_in[i], v, o);
      exp_angle[i] = v;
      exp_ovf[i]   = o;
    end
  endtask

  task automatic launch(input int lat);
    core_lat = lat;
    issued_q.delete();
    done_hits = 0;
    done_cyc  = -1;
    unstable  = 0;
    @(negedge clk);
    start = 1'b1;
    base_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #1;
      if (done_hits > 0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_inputs($urandom, $urandom, $urandom);
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || overflow !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got busy=%b done=%b ovf=%b want 0 0 000", busy, done, overflow);
    end
    total++; if (cordic_bus.cordic_start !== 1'b0 || cordic_bus.cordic_angle !== '0) begin
      bad++; $display("FAIL reset_core_if: got start=%b angle=%h want 0 000000", cordic_bus.cordic_start, cordic_bus.cordic_angle);
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (cordic_out[i] !== '0 || half_out[i] !== '0 || square_out[i] !== '0) begin
        bad++; $display("FAIL reset_lane%0d: got out=%h half=%h sq=%h want zeros", i, cordic_out[i], half_out[i], square_out[i]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit ok;
    set_inputs(32'h3F000000, 32'hBF800000, 32'h00000000);
    launch(1);
    wait_done(60, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout: got no done want done"); end
    total++; if (done_cyc - base_cyc !== 7 || done_hits !== 1) begin
      bad++; $display("FAIL basic_latency: got cycle=%0d hits=%0d want 7 1", done_cyc - base_cyc, done_hits);
    end
    total++; if (issued_q.size() !== 3) begin bad++; $display("FAIL basic_starts: got %0d want 3", issued_q.size()); end
    while (issued_q.size() < 3) issued_q.push_back('x);
    for (int i = 0; i < 3; i++) begin
      total++; if (issued_q[i] !== exp_angle[i]) begin bad++; $display("FAIL basic_angle%0d: got %h want %h", i, issued_q[i], exp_angle[i]); end
      total++; if (cordic_out[i] !== exp_angle[i] + CW'(1)) begin bad++; $display("FAIL basic_out%0d: got %h want %h", i, cordic_out[i], exp_angle[i] + CW'(1)); end
      total++; if (half_out[i] !== half_in[i] || square_out[i] !== square_in[i]) begin
        bad++; $display("FAIL basic_pass%0d: got %h/%h want %h/%h", i, half_out[i], square_out[i], half_in[i], square_in[i]);
      end
    end
    total++; if (overflow !== exp_ovf || exp_ovf !== 3'b000) begin bad++; $display("FAIL basic_ovf: got %b want 000", overflow); end
  endtask

  task automatic test_saturation();
    bit ok;
    set_inputs(32'h40400000, 32'hFF800000, 32'h2EDBE6FF);
    launch(2);
    wait_done(60, ok);
    total++; if (!ok) begin bad++; $display("FAIL sat_timeout: got no done want done"); end
    while (issued_q.size() < 3) issued_q.push_back('x);
    for (int i = 0; i < 3; i++) begin
      total++; if (issued_q[i] !== exp_angle[i]) begin bad++; $display("FAIL sat_angle%0d: got %h want %h", i, issued_q[i], exp_angle[i]); end
      total++; if (cordic_out[i] !== exp_angle[i] + CW'(1)) begin bad++; $display("FAIL sat_out%0d: got %h want %h", i, cordic_out[i], exp_angle[i] + CW'(1)); end
    end
    total++; if (overflow !== exp_ovf) begin bad++; $display("FAIL sat_ovf: got %b want %b", overflow, exp_ovf); end
  endtask

  task automatic test_random();
    bit ok;
    logic [31:0] f [3];
    for (int r = 0; r < 6; r++) begin
      int lat;
      for (int i = 0; i < 3; i++) begin
        int sel;
        logic [7:0] ex;
        sel = $urandom_range(0, 9);
        ex  = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom_range(100, 129));
        f[i] = {1'($urandom_range(0, 1)), ex, 23'($urandom)};
      end
      set_inputs(f[0], f[1], f[2]);
      lat = $urandom_range(1, 4);
      launch(lat);
      wait_done(100, ok);
      total++; if (!ok || done_cyc - base_cyc !== 3 * lat + 4) begin
        bad++; $display("FAIL rand%0d_latency: got %0d want %0d", r, done_cyc - base_cyc, 3 * lat + 4);
      end
      for (int i = 0; i < 3; i++) begin
        total++; if (cordic_out[i] !== exp_angle[i] + CW'(1)) begin
          bad++; $display("FAIL rand%0d_out%0d: x=%h got %h want %h", r, i, x_in[i], cordic_out[i], exp_angle[i] + CW'(1));
        end
      end
      total++; if (overflow !== exp_ovf) begin bad++; $display("FAIL rand%0d_ovf: got %b want %b", r, overflow, exp_ovf); end
      total++; if (half_out[2] !== half_in[2] || square_out[0] !== square_in[0]) begin
        bad++; $display("FAIL rand%0d_pass: got %h/%h want %h/%h", r, half_out[2], square_out[0], half_in[2], square_in[0]);
      end
    end
  endtask

  task automatic test_busy_start();
    bit ok;
    set_inputs(32'h3F000000, 32'hBF800000, 32'h00000000);
    launch(1);
    wait_done(60, ok);
    // Stray core done while idle must not touch the results.
    @(negedge clk); stray_done = 1'b1;
    @(negedge clk); stray_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (cordic_out[i] !== exp_angle[i] + CW'(1)) begin bad++; $display("FAIL stray_out%0d: got %h want %h", i, cordic_out[i], exp_angle[i] + CW'(1)); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stray_busy: got %b want 0", busy); end
    set_inputs(32'h3E800000, 32'hBF000000, 32'h3F400000);
    launch(3);
    @(posedge clk); #1;           // now in WAIT of lane 0
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(80, ok);
    repeat (6) @(posedge clk);
    #1;
    total++; if (!ok || issued_q.size() !== 3 || done_hits !== 1) begin
      bad++; $display("FAIL busy_start_count: got starts=%0d dones=%0d want 3 1", issued_q.size(), done_hits);
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (cordic_out[i] !== exp_angle[i] + CW'(1)) begin bad++; $display("FAIL busy_start_out%0d: got %h want %h", i, cordic_out[i], exp_angle[i] + CW'(1)); end
    end
  endtask

  task automatic test_clk_en_stall();
    bit ok;
    int starts_in_stall;
    set_inputs(32'h3F000000, 32'hBF800000, 32'h00000000);
    launch(1);
    clk_en = 1'b0;                // stall while in ISSUE of lane 0
    repeat (3) @(posedge clk);
    starts_in_stall = issued_q.size();
    #1 clk_en = 1'b1;
    wait_done(60, ok);
    total++; if (starts_in_stall !== 0) begin bad++; $display("FAIL stall_start_low: got %0d starts want 0", starts_in_stall); end
    total++; if (!ok || issued_q.size() !== 3 || done_cyc - base_cyc !== 10) begin
      bad++; $display("FAIL stall_count: got starts=%0d cycle=%0d want 3 10", issued_q.size(), done_cyc - base_cyc);
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (cordic_out[i] !== exp_angle[i] + CW'(1)) begin bad++; $display("FAIL stall_out%0d: got %h want %h", i, cordic_out[i], exp_angle[i] + CW'(1)); end
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    set_inputs(32'h3F000000, 32'hBF800000, 32'h00000000);
    launch(3);
    for (int i = 0; i < 40 && issued_q.size() < 2; i++) @(negedge clk);
    @(posedge clk);               // now in WAIT of lane 1
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || overflow !== 3'b000 || cordic_bus.cordic_angle !== '0) begin
      bad++; $display("FAIL midrst_state: got busy=%b ovf=%b angle=%h want 0 000 000000", busy, overflow, cordic_bus.cordic_angle);
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (cordic_out[i] !== '0 || half_out[i] !== '0 || square_out[i] !== '0) begin
        bad++; $display("FAIL midrst_lane%0d: got %h %h %h want zeros", i, cordic_out[i], half_out[i], square_out[i]);
      end
    end
    rst = 1'b0;
    repeat (5) @(posedge clk);    // late core done lands here
    #1;
    total++; if (cordic_out[1] !== '0 || busy !== 1'b0) begin
      bad++; $display("FAIL midrst_late_done: got out=%h busy=%b want 000000 0", cordic_out[1], busy);
    end
    launch(1);
    wait_done(60, ok);
    total++; if (!ok || done_cyc - base_cyc !== 7) begin bad++; $display("FAIL midrst_rerun_latency: got %0d want 7", done_cyc - base_cyc); end
    for (int i = 0; i < 3; i++) begin
      total++; if (cordic_out[i] !== exp_angle[i] + CW'(1)) begin bad++; $display("FAIL midrst_rerun_out%0d: got %h want %h", i, cordic_out[i], exp_angle[i] + CW'(1)); end
    end
  endtask

  task automatic test_long_latency();
    bit ok;
    set_inputs(32'h3F7FFFFF, 32'hBE000000, 32'h3FC00000);
    launch(5);
    wait_done(100, ok);
    total++; if (!ok || done_cyc - base_cyc !== 19) begin bad++; $display("FAIL long_latency: got %0d want 19", done_cyc - base_cyc); end
    total++; if (unstable !== 0) begin bad++; $display("FAIL long_angle_stable: got %0d changes want 0", unstable); end
    for (int i = 0; i < 3; i++) begin
      total++; if (cordic_out[i] !== exp_angle[i] + CW'(1)) begin bad++; $display("FAIL long_out%0d: got %h want %h", i, cordic_out[i], exp_angle[i] + CW'(1)); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    set_inputs(32'h3F000000, 32'hBF800000, 32'h00000000);
    launch(1);
    for (int i = 0; i < 40 && done !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    start = 1'b1;                 // coincides with the DONE cycle
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || issued_q.size() !== 3 || done_hits !== 1) begin
      bad++; $display("FAIL b2b_done_start: got busy=%b starts=%0d dones=%0d want 0 3 1", busy, issued_q.size(), done_hits);
    end
    set_inputs(32'hBF400000, 32'h3DCCCCCD, 32'hC0000000);
    launch(2);
    wait_done(60, ok);
    total++; if (!ok || done_cyc - base_cyc !== 10) begin bad++; $display("FAIL b2b_latency: got %0d want 10", done_cyc - base_cyc); end
    for (int i = 0; i < 3; i++) begin
      total++; if (cordic_out[i] !== exp_angle[i] + CW'(1)) begin bad++; $display("FAIL b2b_out%0d: got %h want %h", i, cordic_out[i], exp_angle[i] + CW'(1)); end
    end
    total++; if (overflow !== exp_ovf) begin bad++; $display("FAIL b2b_ovf: got %b want %b", overflow, exp_ovf); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_random();
    test_busy_start();
    test_clk_en_stall();
    test_reset_mid_run();
    test_long_latency();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
